// File: rtl/aes_key_expand_128.sv
// ---------------------------------------------------------------------------
// aes_key_expand_128 : AES-128 key schedule, one round key per handshake,
//                      SubWord supplied by an external combinational S-box.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_key_expand_128 (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam logic [3:0] C_LAST_ROUND = 4'd10;

  logic [0:0]   state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [31:0]  temp;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [7:0]   rcon_next;

  assign sbox_in   = {rk_q[23:0], rk_q[31:24]};
  assign temp      = sbox_out ^ {rcon_q, 24'h0};
  assign w0_n      = rk_q[127:96] ^ temp;
  assign w1_n      = rk_q[95:64]  ^ w0_n;
  assign w2_n      = rk_q[63:32]  ^ w1_n;
  assign w3_n      = rk_q[31:0]   ^ w2_n;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  assign rk_valid  = (state_q == S_EMIT);
  assign busy      = (state_q != S_IDLE);
  assign done      = rk_valid && (idx_q == C_LAST_ROUND);
  assign round_key = rk_q;
  assign rk_idx    = idx_q;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EMIT;
          rk_d    = key;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          // Last key accepted: round_key/rk_idx keep their final values.
          if (idx_q == C_LAST_ROUND) begin
            state_d = S_IDLE;
          end else begin
            rk_d   = {w0_n, w1_n, w2_n, w3_n};
            idx_d  = idx_q + 4'd1;
            rcon_d = rcon_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rk_q    <= 128'h0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand_128.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand_128 : scoreboard bench for the AES-128 key schedule.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_key_expand_128;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  aes_key_expand_128 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .sbox_in   (sbox_in),
    .sbox_out  (sbox_out),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .rk_idx    (rk_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference S-box: multiplicative inverse in GF(2^8) followed by the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_b(input logic [7:0] v);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    if (v == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  always_comb begin
    sbox_out = {sbox_b(sbox_in[31:24]), sbox_b(sbox_in[23:16]),
                sbox_b(sbox_in[15:8]),  sbox_b(sbox_in[7:0])};
  end

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K0 = 128'h0;

  logic [127:0] k1_tab [0:10];
  initial begin
    k1_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k1_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    k1_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    k1_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    k1_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    k1_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    k1_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    k1_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    k1_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    k1_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    k1_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  end

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
    bit           chk_key;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   valid_cycles = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tot++;
    if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
    else n_pass++;
  endtask

  // which = 0: FIPS-197 key, all rounds known; which = 1: all-zero key, rounds 0/1/10 known.
  task automatic push_sched(input int which);
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      e.idx = 4'(i);
      if (which == 0) begin
        e.rk = k1_tab[i]; e.chk_key = 1'b1;
      end else begin
        e.chk_key = (i == 0) || (i == 1) || (i == 10);
        e.rk = (i == 1)  ? 128'h62636363626363636263636362636363 :
               (i == 10) ? 128'hb4ef5bcb3e92e21123e951cf6f8f188e : K0;
      end
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rk_valid) valid_cycles <= valid_cycles + 1;
  end

  // Monitor: pops one expectation per handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rk_valid) begin
      check("sbox_in_rotword", {96'h0, sbox_in}, {96'h0, round_key[23:0], round_key[31:24]});
      if (rk_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", 128'h1, 128'h0);
        end else begin
          e = exp_q.pop_front();
          check("rk_idx", {124'h0, rk_idx}, {124'h0, e.idx});
          check("done", {127'h0, done}, {127'h0, (e.idx == 4'd10)});
          if (e.chk_key) check("round_key", round_key, e.rk);
        end
      end
    end else begin
      check("done_idle", {127'h0, done}, 128'h0);
    end
  end

  task automatic start_key(input logic [127:0] k);
    start = 1'b1;
    key   = k;
    @(posedge clk); #1;
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idx(input int n);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (rk_valid && rk_idx == 4'(n)) hit = 1'b1;
    end
    if (!hit) check("wait_idx_timeout", 128'h0, 128'h1);
  endtask

  task automatic wait_idle();
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (!rk_valid && !busy) hit = 1'b1;
    end
    if (!hit) check("wait_idle_timeout", 128'h0, 128'h1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rk_valid"}, {127'h0, rk_valid}, 128'h0);
    check({tag, "_busy"},     {127'h0, busy},     128'h0);
    check({tag, "_done"},     {127'h0, done},     128'h0);
    check({tag, "_rk_idx"},   {124'h0, rk_idx},   128'h0);
    check({tag, "_round_key"}, round_key,         128'h0);
  endtask

  initial begin
    logic [127:0] held_rk;
    reset = 1'b0; start = 1'b0; rk_ready = 1'b1; key = '0;
    #1 reset = 1'b1;
    #2 check_reset_state("por");

    // Plain run, start raised as reset releases.
    @(posedge clk); #1;
    reset = 1'b0;
    valid_cycles = 0;
    push_sched(0);
    start_key(K1);
    check("first_after_reset_valid", {127'h0, rk_valid}, 128'h1);
    check("round0_latency_idx", {124'h0, rk_idx}, 128'h0);
    wait_idle();
    check("k1_valid_cycles", 128'(valid_cycles), 128'd11);
    check("hold_last_key", round_key, k1_tab[10]);
    check("hold_last_idx", {124'h0, rk_idx}, 128'd10);

    // All-zero key.
    @(posedge clk); #1;
    valid_cycles = 0;
    push_sched(1);
    start_key(K0);
    wait_idle();
    check("k0_valid_cycles", 128'(valid_cycles), 128'd11);

    // Backpressure for 5 cycles while round 3 is presented.
    @(posedge clk); #1;
    valid_cycles = 0;
    push_sched(0);
    start_key(K1);
    wait_idx(2);
    @(posedge clk); #1;
    rk_ready = 1'b0;
    held_rk  = round_key;
    check("bp_entry_idx", {124'h0, rk_idx}, 128'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_key", round_key, k1_tab[3]);
      check("bp_hold_idx", {124'h0, rk_idx}, 128'd3);
      check("bp_hold_valid", {127'h0, rk_valid}, 128'h1);
      @(posedge clk); #1;
    end
    check("bp_key_unchanged", round_key, held_rk);
    rk_ready = 1'b1;
    wait_idle();
    check("bp_valid_cycles", 128'(valid_cycles), 128'd16);

    // start pulses at round 4 and at the final handshake must be ignored.
    @(posedge clk); #1;
    valid_cycles = 0;
    push_sched(0);
    start_key(K1);
    wait_idx(4);
    start = 1'b1; key = {128{1'b1}};
    @(posedge clk); #1;
    start = 1'b0;
    wait_idx(10);
    start = 1'b1; key = K0;
    @(posedge clk); #1;
    check("start_at_final_ignored", {127'h0, rk_valid}, 128'h0);
    check("start_at_final_busy", {127'h0, busy}, 128'h0);
    push_sched(1);
    @(posedge clk); #1;
    start = 1'b0;
    key   = K1;
    check("start_next_cycle_valid", {127'h0, rk_valid}, 128'h1);
    wait_idle();
    check("ignored_start_cycles", 128'(valid_cycles), 128'd22);

    // Asynchronous reset in the middle of an expansion.
    @(posedge clk); #1;
    push_sched(0);
    start_key(K1);
    wait_idx(6);
    #2 reset = 1'b1;
    #1 check_reset_state("async");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    push_sched(0);
    start_key(K1);
    check("restart_valid", {127'h0, rk_valid}, 128'h1);
    wait_idle();

    check("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
